// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder block.
package scan_decoder_pkg;

   localparam int unsigned MAX_SEL_W = 8;
   localparam int unsigned MAX_OUT   = 2**MAX_SEL_W;

   typedef enum logic [1:0] {
      StIdle,
      StDrive,
      StGap
   } state_e;

   // Full-width active-low one-cold vector; callers truncate to their output count.
   function automatic logic [MAX_OUT-1:0] onecold_n(input logic [MAX_SEL_W-1:0] idx);
      logic [MAX_OUT-1:0] v;
      v      = '1;
      v[idx] = 1'b0;
      return v;
   endfunction

endpackage

// File: rtl/scan_decoder_onecold_dec.sv
// Combinational SEL_W-to-2**SEL_W active-low decoder; all outputs high when en is low.
module scan_decoder_onecold_dec
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 3
) (
   input  logic [SEL_W-1:0]    idx,
   input  logic                en,
   output logic [2**SEL_W-1:0] dec_n
);

   localparam int unsigned N_OUT = 2**SEL_W;

   always_comb begin
      dec_n = '1;
      if (en) begin
         dec_n = N_OUT'(onecold_n(MAX_SEL_W'(idx)));
      end
   end

endmodule

// File: rtl/scan_decoder.sv
// Registered active-low one-cold decoder with manual decode and auto-scan modes,
// break-before-make blanking between driven outputs.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned DWELL = 4,
   parameter int unsigned BLANK = 1
) (
   input  logic                clk,
   input  logic                rst_,
   input  logic                enb_,
   input  logic                mode,
   input  logic [SEL_W-1:0]    sel,
   output logic [2**SEL_W-1:0] o,
   output logic [SEL_W-1:0]    cur,
   output logic                wrap
);

   localparam int unsigned N_OUT   = 2**SEL_W;
   localparam int unsigned CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
   localparam bit HAS_GAP = (BLANK > 0);

   if (DWELL < 1 || SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_param_check
      $error("scan_decoder: need DWELL >= 1 and 1 <= SEL_W <= %0d", MAX_SEL_W);
   end

   state_e           state_q, state_d;
   logic [SEL_W-1:0] cur_q, cur_d, target;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             mode_q;
   logic             drive_en;
   logic [N_OUT-1:0] o_q, o_d;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= StIdle;
         cur_q   <= '0;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
         mode_q  <= 1'b0;
         o_q     <= '1;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
         mode_q  <= mode;
         o_q     <= o_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      // Scan keeps its own position; manual follows sel.
      target  = mode ? cur_q : sel;
      if (enb_) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StDrive;
               cur_d   = target;
               cnt_d   = '0;
            end
            StDrive: begin
               // A mode change retargets exactly like an index change.
               if ((mode != mode_q) || (!mode && (sel != cur_q))) begin
                  cur_d   = target;
                  cnt_d   = '0;
                  state_d = HAS_GAP ? StGap : StDrive;
               end else if (mode) begin
                  if (cnt_q == DWELL_LAST) begin
                     cur_d   = cur_q + 1'b1;
                     cnt_d   = '0;
                     wrap_d  = &cur_q;
                     state_d = HAS_GAP ? StGap : StDrive;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StGap: begin
               cur_d = target;
               if (cnt_q == BLANK_LAST) begin
                  state_d = StDrive;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      drive_en = (state_d == StDrive);
   end

   scan_decoder_onecold_dec #(
      .SEL_W (SEL_W)
   ) u_dec (
      .idx   (cur_d),
      .en    (drive_en),
      .dec_n (o_d)
   );

   assign o    = o_q;
   assign cur  = cur_q;
   assign wrap = wrap_q;

endmodule
